// File: rtl/relu_frame_buffer.sv
// ReLU activation feeding a two-bank ping-pong frame buffer between linear layers.
// Define RELU_CLIP_EN to clip stored words at CLIP_VAL instead of plain ReLU.
module relu_frame_buffer #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 20,
    parameter int                ADDR_W   = 5,
    parameter logic [DATA_W-1:0] CLIP_VAL = 32'h06000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              relu_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_ready,
    input  logic              frame_release,
    output logic              overflow,
    output logic              addr_err
);

`ifdef RELU_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;

    bank_st_t          bank_st [2];
    logic [DEPTH-1:0]  mask    [2];
    logic [DATA_W-1:0] mem     [2][DEPTH];
    logic              wr_bank;
    logic              rd_bank;

    logic              other_bank;
    logic              wr_sel;
    logic              in_range;
    logic              rd_in_range;
    logic              do_write;
    logic              do_drop;
    logic              release_ok;
    logic [DEPTH-1:0]  wr_mask;
    logic [DATA_W-1:0] relu_data;

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
        if (x[DATA_W-1]) return '0;
        if (CLIP_EN && ($signed(x) > $signed(CLIP_VAL))) return CLIP_VAL;
        return x;
    endfunction

    assign frame_ready = (bank_st[rd_bank] == FULL);

    // A full write bank hands over to the other bank as soon as that one is free, so a
    // write arriving in the hand-over cycle already lands in the new bank.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        other_bank  = ~wr_bank;
        wr_sel      = wr_bank;
        if (bank_st[wr_bank] == FULL && bank_st[other_bank] != FULL)
            wr_sel = other_bank;
        in_range    = (in_addr <= LAST_ADDR);
        rd_in_range = (rd_addr <= LAST_ADDR);
        do_write    = relu_en && in_valid && in_range && (bank_st[wr_sel] != FULL);
        do_drop     = relu_en && in_valid && in_range && (bank_st[wr_sel] == FULL);
        release_ok  = relu_en && frame_release && frame_ready;
        wr_mask     = mask[wr_sel] | ({{(DEPTH-1){1'b0}}, 1'b1} << in_addr);
        relu_data   = relu(in_data);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b] <= EMPTY;
                mask[b]    <= '0;
            end
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
            addr_err <= 1'b0;
        end else if (!relu_en) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b] <= EMPTY;
                mask[b]    <= '0;
            end
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            wr_bank <= wr_sel;
            if (do_write) begin
                mask[wr_sel]    <= wr_mask;
                bank_st[wr_sel] <= (&wr_mask) ? FULL : FILLING;
            end
            // The released bank is never wr_sel here: a FULL read bank is never written.
            if (release_ok) begin
                mask[rd_bank]    <= '0;
                bank_st[rd_bank] <= EMPTY;
                rd_bank          <= ~rd_bank;
            end
            if (do_drop)
                overflow <= 1'b1;
            if (in_valid && !in_range)
                addr_err <= 1'b1;
            if (rd_en) begin
                rd_valid <= 1'b1;
                rd_data  <= (frame_ready && rd_in_range) ? mem[rd_bank][rd_addr] : '0;
            end else begin
                rd_valid <= 1'b0;
            end
        end
    end

    // NOTE: frame storage is not reset; the cleared masks/bank states make stale words unreadable.
    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_sel][in_addr] <= relu_data;
    end

endmodule

// File: tb/tb_relu_frame_buffer.sv
// Scoreboard bench for relu_frame_buffer: a frame-FIFO reference model predicts reads and flags.
module tb_relu_frame_buffer;

    localparam int          DEPTH = 20;
    localparam logic [31:0] CLIP  = 32'h06000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        relu_en;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_addr;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        frame_ready;
    logic        frame_release;
    logic        overflow;
    logic        addr_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one partially collected frame plus a FIFO of up to two complete frames.
    logic [31:0] m_fill [DEPTH];
    bit          m_set  [DEPTH];
    int          m_cnt;
    logic [31:0] m_frm  [2][DEPTH];
    int          m_nf;
    bit          m_ovf;
    bit          m_aerr;
    logic [31:0] exp_q [$];

    relu_frame_buffer dut (
        .clk(clk), .rst_n(rst_n), .relu_en(relu_en),
        .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_ready(frame_ready), .frame_release(frame_release),
        .overflow(overflow), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] relu_ref(input logic [31:0] x);
        if ($signed(x) < 0) return 32'h0;
`ifdef RELU_CLIP_EN
        if ($signed(x) > $signed(CLIP)) return CLIP;
`endif
        return x;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) m_set[i] = 1'b0;
        m_cnt  = 0;
        m_nf   = 0;
        m_ovf  = 1'b0;
        m_aerr = 1'b0;
    endfunction

    task automatic check_flags();
        check("frame_ready", 32'(frame_ready), 32'(m_nf > 0));
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("addr_err",    32'(addr_err),    32'(m_aerr));
    endtask

    // One clock of stimulus; the model is advanced from the pre-edge state.
    task automatic step(input bit v, input logic [4:0] a, input logic [31:0] d,
                        input bit re, input logic [4:0] ra, input bit rel);
        bit rel_ok;
        in_valid      = v;
        in_addr       = a;
        in_data       = d;
        rd_en         = re;
        rd_addr       = ra;
        frame_release = rel;
        if (re) begin
            if (m_nf > 0 && int'(ra) < DEPTH) exp_q.push_back(m_frm[0][ra]);
            else exp_q.push_back(32'h0);
        end
        rel_ok = rel && (m_nf > 0);
        if (v) begin
            if (int'(a) >= DEPTH) m_aerr = 1'b1;
            else if (m_nf == 2) m_ovf = 1'b1;
            else begin
                m_fill[a] = relu_ref(d);
                if (!m_set[a]) begin
                    m_set[a] = 1'b1;
                    m_cnt++;
                end
                if (m_cnt == DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        m_frm[m_nf][i] = m_fill[i];
                        m_set[i] = 1'b0;
                    end
                    m_nf++;
                    m_cnt = 0;
                end
            end
        end
        if (rel_ok) begin
            for (int i = 0; i < DEPTH; i++) m_frm[0][i] = m_frm[1][i];
            m_nf--;
        end
        @(posedge clk);
        #1;
        check_flags();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic rd(input logic [4:0] ra);
        step(1'b0, 5'd0, 32'h0, 1'b1, ra, 1'b0);
    endtask

    task automatic rel();
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    endtask

    // Writes every address once in random order with random data.
    task automatic fill_frame(input bit rel_on_last);
        int perm [DEPTH];
        for (int i = 0; i < DEPTH; i++) perm[i] = i;
        for (int i = DEPTH - 1; i > 0; i--) begin
            int j = int'($urandom_range(0, i));
            int t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 5'(perm[i]), $urandom, 1'b0, 5'd0, rel_on_last && (i == DEPTH - 1));
    endtask

    task automatic flush();
        relu_en  = 1'b0;
        in_valid = 1'b0;
        rd_en    = 1'b0;
        frame_release = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        relu_en = 1'b1;
        check_flags();
        check("flush_rd_valid", 32'(rd_valid), 32'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got rd_valid=1 data %h, expected no read", rd_data);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; relu_en = 1'b1; in_valid = 1'b0; in_data = '0; in_addr = '0;
        rd_en = 1'b0; rd_addr = '0; frame_release = 1'b0;
        model_clear();
        #12;
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check_flags();
        rst_n = 1'b1;

        // Ramp frame from -8.0 to +11.0, then read it back in order.
        for (int k = 0; k < DEPTH; k++) wr(5'(k), 32'(k) * 32'h01000000 - 32'h08000000);
        for (int k = 0; k < DEPTH; k++) rd(5'(k));
        rd(5'd20);
        rel();
        rd(5'd4);

        // Two frames, an overflowing 41st write, release, then read the second frame.
        flush();
        fill_frame(1'b0);
        fill_frame(1'b0);
        wr(5'd7, 32'h00001234);
        rel();
        for (int k = 0; k < DEPTH; k += 3) rd(5'(k));
        flush();

        // Out-of-range and duplicate addresses.
        wr(5'd25, 32'h00000777);
        wr(5'd3, 32'h00000100);
        wr(5'd3, 32'h00000200);
        for (int k = 0; k < DEPTH - 1; k++) if (k != 3) wr(5'(k), $urandom);
        wr(5'd19, 32'h7fffffff);
        rd(5'd3);
        rd(5'd25);
        rd(5'd19);
        flush();

        // Completing write of frame B in the same cycle as the release of frame A.
        fill_frame(1'b0);
        fill_frame(1'b1);
        wr(5'd5, 32'h00abcdef);
        rd(5'd5);
        rd(5'd0);
        rel();
        fill_frame(1'b0);
        rd(5'd5);
        rd(5'd12);
        flush();

        // Asynchronous reset mid-frame.
        for (int k = 0; k < 10; k++) wr(5'(k), $urandom);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_clear();
        check("arst_rd_data", rd_data, 32'h0);
        check("arst_rd_valid", 32'(rd_valid), 32'h0);
        check_flags();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) wr(5'(k), $urandom);
        rd(5'd9);
        flush();

        // Large positive word: clipped only when the clip option is built in.
        wr(5'd0, 32'h0A000000);
        for (int k = 1; k < DEPTH; k++) wr(5'(k), $urandom);
        rd(5'd0);
        flush();

        // Random mix of writes, reads and releases.
        for (int n = 0; n < 500; n++) begin
            bit          v   = ($urandom_range(0, 9) < 7);
            logic [4:0]  a   = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(20, 31))
                                                             : 5'($urandom_range(0, 19));
            bit          re  = ($urandom_range(0, 2) == 0);
            logic [4:0]  ra  = 5'($urandom_range(0, 23));
            bit          rl  = ($urandom_range(0, 11) == 0);
            step(v, a, $urandom, re, ra, rl);
        end

        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        check("rd_pending", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
